// File: rtl/pwm_gate_ctrl.sv
// pwm_gate_ctrl
// Sequenced gate-drive controller. Produces the raw phase signal `ctrl` and a
// complementary, dead-time-protected gate pair. Period, duty and dead time are
// loaded into pending registers and promoted to the active set in IDLE/FAULT
// immediately, or at a period boundary while running. Duty ramps in through a
// soft-start sequence, and a latched fault forces everything off.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   en                    run request (level)
//   load                  strobe capturing period_in/duty_in/dt_in
//   period_in, duty_in    period and high-phase length in clocks (CNT_W)
//   dt_in                 dead time in clocks (DT_W)
//   fault, fault_clr      fault request (level) and acknowledge
//   ctrl                  phase signal, 1 selects +1.0
//   gate_hi, gate_lo      high-/low-side gates, never both 1
//   cycle_start           pulse on the first clock of each period
//   state                 IDLE=0, SOFTSTART=1, RUN=2, FAULT=3
module pwm_gate_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DT_W    = 8,
    parameter int unsigned SS_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] duty_in,
    input  logic [DT_W-1:0]  dt_in,
    input  logic             fault,
    input  logic             fault_clr,
    output logic             ctrl,
    output logic             gate_hi,
    output logic             gate_lo,
    output logic             cycle_start,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOFT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(2);
    localparam logic [CNT_W:0]   SS_INC  = (CNT_W+1)'(SS_STEP);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] d_eff_q, d_eff_d;
    logic [DT_W-1:0]  dt_cnt_q, dt_cnt_d;
    logic [CNT_W-1:0] per_p_q, per_p_d, duty_p_q, duty_p_d;
    logic [DT_W-1:0]  dt_p_q, dt_p_d;
    logic [CNT_W-1:0] per_a_q, per_a_d, duty_a_q, duty_a_d;
    logic [DT_W-1:0]  dt_a_q, dt_a_d;
    logic             ctrl_q, ctrl_d;
    logic             gate_hi_q, gate_hi_d;
    logic             gate_lo_q, gate_lo_d;
    logic             cycle_start_q, cycle_start_d;

    logic [CNT_W-1:0] per_eff;
    logic             wrap;
    logic [CNT_W:0]   ss_sum;
    logic             running_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_eff_d  = d_eff_q;
        per_a_d  = per_a_q;
        duty_a_d = duty_a_q;
        dt_a_d   = dt_a_q;

        // Fault outranks load: a load coinciding with fault is dropped.
        if (load && !fault) begin
            per_p_d  = period_in;
            duty_p_d = duty_in;
            dt_p_d   = dt_in;
        end else begin
            per_p_d  = per_p_q;
            duty_p_d = duty_p_q;
            dt_p_d   = dt_p_q;
        end

        per_eff = (per_a_q < PER_MIN) ? PER_MIN : per_a_q;
        wrap    = (cnt_q >= per_eff - CNT_W'(1));

        case (state_q)
            ST_IDLE, ST_FAULT: begin
                // Promotion uses the _d pending values so a load here is
                // active on the very next clock.
                per_a_d  = per_p_d;
                duty_a_d = duty_p_d;
                dt_a_d   = dt_p_d;
                cnt_d    = '0;
                d_eff_d  = '0;
                if (fault) begin
                    state_d = ST_FAULT;
                end else if (state_q == ST_IDLE) begin
                    if (en) begin
                        state_d = ST_SOFT;
                        d_eff_d = ({1'b0, duty_a_d} < SS_INC) ? duty_a_d : SS_INC[CNT_W-1:0];
                    end
                end else if (fault_clr && !en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (fault || !en) begin
                    state_d = fault ? ST_FAULT : ST_IDLE;
                    cnt_d   = '0;
                    d_eff_d = '0;
                end else if (wrap) begin
                    // Boundary: promote the pending set (a load on this same
                    // clock only reaches pending and waits one more period).
                    cnt_d    = '0;
                    per_a_d  = per_p_q;
                    duty_a_d = duty_p_q;
                    dt_a_d   = dt_p_q;
                    if (state_q == ST_RUN) begin
                        d_eff_d = duty_a_d;
                    end else if (({1'b0, d_eff_q} + SS_INC) >= {1'b0, duty_a_d}) begin
                        d_eff_d = duty_a_d;
                        state_d = ST_RUN;
                    end else begin
                        d_eff_d = ss_sum[CNT_W-1:0];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        ss_sum = {1'b0, d_eff_q} + SS_INC;

        // Outputs are computed from next-state values so the registered
        // outputs line up with the registered cnt/d_eff/state.
        running_d     = (state_d == ST_SOFT) || (state_d == ST_RUN);
        ctrl_d        = running_d && (cnt_d < d_eff_d);
        cycle_start_d = running_d && (cnt_d == '0);

        if (!running_d) begin
            dt_cnt_d = '0;
        end else if (ctrl_d != ctrl_q) begin
            dt_cnt_d = dt_a_d;
        end else if (dt_cnt_q != '0) begin
            dt_cnt_d = dt_cnt_q - DT_W'(1);
        end else begin
            dt_cnt_d = dt_cnt_q;
        end

        gate_hi_d = ctrl_d && (dt_cnt_d == '0);
        gate_lo_d = running_d && !ctrl_d && (dt_cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            d_eff_q       <= '0;
            dt_cnt_q      <= '0;
            per_p_q       <= PER_MIN;
            duty_p_q      <= '0;
            dt_p_q        <= '0;
            per_a_q       <= PER_MIN;
            duty_a_q      <= '0;
            dt_a_q        <= '0;
            ctrl_q        <= 1'b0;
            gate_hi_q     <= 1'b0;
            gate_lo_q     <= 1'b0;
            cycle_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            d_eff_q       <= d_eff_d;
            dt_cnt_q      <= dt_cnt_d;
            per_p_q       <= per_p_d;
            duty_p_q      <= duty_p_d;
            dt_p_q        <= dt_p_d;
            per_a_q       <= per_a_d;
            duty_a_q      <= duty_a_d;
            dt_a_q        <= dt_a_d;
            ctrl_q        <= ctrl_d;
            gate_hi_q     <= gate_hi_d;
            gate_lo_q     <= gate_lo_d;
            cycle_start_q <= cycle_start_d;
        end
    end

    assign ctrl        = ctrl_q;
    assign gate_hi     = gate_hi_q;
    assign gate_lo     = gate_lo_q;
    assign cycle_start = cycle_start_q;
    assign state       = state_q;

endmodule
